// File: rtl/reg_dump.sv
// Register file dump engine: walks registers 0..NUM_REGS-1 through one read port
// and streams a framed byte sequence (0xA5 header, hi/lo byte pairs, XOR checksum).
module reg_dump #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [15:0]       rd_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE
    } state_t;

    localparam logic [7:0]        HEADER   = 8'hA5;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] index, index_nx;
    logic [7:0]        csum, csum_nx;
    logic [15:0]       snap, snap_nx;
    logic              xfer;

    // Stream handshake: a byte moves on a rising edge where out_valid && out_ready.
    // out_valid and out_data depend only on state/snap/csum, so once raised they
    // hold until that edge, and out_ready never feeds back into them combinationally.
    assign xfer = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            index <= '0;
            csum  <= '0;
            snap  <= '0;
        end else begin
            state <= state_nx;
            index <= index_nx;
            csum  <= csum_nx;
            snap  <= snap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        index_nx = index;
        csum_nx  = csum;
        snap_nx  = snap;
        case (state)
            S_IDLE: begin
                if (start) begin
                    index_nx = '0;
                    csum_nx  = '0;
                    state_nx = S_HDR;
                end
            end
            S_HDR: begin
                if (xfer) state_nx = S_LOAD;
            end
            S_LOAD: begin
                // Each register is sampled when reached; the dump is not atomic.
                snap_nx  = rd_data;
                state_nx = S_HI;
            end
            S_HI: begin
                if (xfer) begin
                    csum_nx  = csum ^ snap[15:8];
                    state_nx = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    csum_nx = csum ^ snap[7:0];
                    if (index == LAST_IDX) begin
                        state_nx = S_CSUM;
                    end else begin
                        index_nx = index + 1'b1;
                        state_nx = S_LOAD;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) state_nx = S_DONE;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state)
            S_HDR: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = HEADER;
            end
            S_LOAD: begin
                busy = 1'b1;
            end
            S_HI: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = snap[15:8];
            end
            S_LO: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = snap[7:0];
            end
            S_CSUM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = csum;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign rd_addr = index;

endmodule

// File: tb/tb_reg_dump.sv
// Directed bench for reg_dump: frames captured byte by byte and compared
// against a frame built from the bench's own register file contents.
module tb_reg_dump;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    logic [15:0] regs [16];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    int vectors = 0;
    int errors  = 0;
    int busy_cycles;
    bit aborted;

    reg_dump #(.NUM_REGS(16), .ADDR_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign rd_data = regs[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic build_exp();
        logic [7:0] c;
        c = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(regs[i][15:8]);
            exp_q.push_back(regs[i][7:0]);
            c = c ^ regs[i][15:8] ^ regs[i][7:0];
        end
        exp_q.push_back(c);
    endtask

    task automatic check_frame(input string name);
        build_exp();
        check({name, " frame length"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s byte %0d", name, i), got_q[i], exp_q[i]);
    endtask

    // Called at a negedge; pulses start so the DUT is in HDR at the next negedge.
    task automatic start_frame(input string name);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, " hdr valid"}, out_valid, 1);
        check({name, " hdr data"}, out_data, 8'hA5);
        check({name, " hdr busy"}, busy, 1);
    endtask

    // mode 0: ready high; 1: ready toggles 1010..; 2: ready low 5 cycles on reg3 HI.
    // start_mode 1: one-cycle start at cycle 10; 2: start high from cycle 40 onward.
    task automatic collect(input string name, input int mode, input int start_mode,
                           input int abort_size);
        int         cyc;
        int         stall_left;
        bit         prev_stall;
        bit         seen_done;
        bit         rdy;
        logic [7:0] prev_data;
        cyc = 0;
        stall_left = 5;
        prev_stall = 0;
        seen_done = 0;
        prev_data = 8'h00;
        got_q.delete();
        busy_cycles = 0;
        aborted = 0;
        while (!seen_done && cyc < 400) begin
            if (prev_stall) begin
                check({name, " stall valid"}, out_valid, 1);
                check({name, " stall data"}, out_data, prev_data);
            end
            if (abort_size >= 0 && out_valid && got_q.size() == abort_size) begin
                aborted = 1;
                return;
            end
            rdy = 1'b1;
            if (mode == 1) rdy = (cyc % 2 == 0);
            else if (mode == 2 && out_valid && got_q.size() == 7 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            out_ready = rdy;
            if (start_mode == 1) start = (cyc == 10);
            else if (start_mode == 2 && cyc >= 40) start = 1'b1;
            if (busy) busy_cycles++;
            if (done) seen_done = 1;
            else if (out_valid && rdy) got_q.push_back(out_data);
            prev_stall = out_valid && !rdy;
            prev_data = out_data;
            cyc++;
            @(negedge clk);
        end
        check({name, " done seen"}, seen_done, 1);
        check({name, " done one cycle"}, done, 0);
        check({name, " idle busy"}, busy, 0);
        check({name, " idle valid"}, out_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst valid", out_valid, 0);
        check("rst data", out_data, 8'h00);
        check("rst addr", rd_addr, 4'h0);
        reset = 1'b0;
        @(negedge clk);
        check("idle no start", busy, 0);

        // Cleared register file
        start_frame("zero");
        collect("zero", 0, 0, -1);
        check("zero busy cycles", busy_cycles, 50);
        check_frame("zero");
        check("zero csum", got_q[33], 8'h00);

        // reg[i] = i*0x1111
        for (int i = 0; i < 16; i++) regs[i] = 16'(i * 16'h1111);
        start_frame("ramp");
        collect("ramp", 0, 0, -1);
        check_frame("ramp");
        check("ramp r3 hi", got_q[7], 8'h33);
        check("ramp r3 lo", got_q[8], 8'h33);
        check("ramp r15 hi", got_q[31], 8'hFF);
        check("ramp r15 lo", got_q[32], 8'hFF);
        check("ramp csum", got_q[33], 8'h00);

        // Single non-zero register
        for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
        regs[3] = 16'h12F0;
        start_frame("r3");
        collect("r3", 0, 0, -1);
        check_frame("r3");
        check("r3 hi", got_q[7], 8'h12);
        check("r3 lo", got_q[8], 8'hF0);
        check("r3 csum", got_q[33], 8'hE2);
        check("r3 busy cycles", busy_cycles, 50);

        // Backpressure: toggling ready, then a 5-cycle stall on an HI byte
        for (int i = 0; i < 16; i++) regs[i] = {4'(i), 4'hA, 8'hC3 ^ 8'(i * 7)};
        start_frame("toggle");
        collect("toggle", 1, 0, -1);
        check_frame("toggle");
        start_frame("stall");
        collect("stall", 2, 0, -1);
        check_frame("stall");
        check("stall busy cycles", busy_cycles, 55);

        // start pulse mid-frame is ignored
        start_frame("midstart");
        collect("midstart", 0, 1, -1);
        check_frame("midstart");
        check("midstart busy cycles", busy_cycles, 50);

        // start held through DONE: exactly one new frame from IDLE
        start_frame("hold");
        collect("hold", 0, 2, -1);
        check_frame("hold");
        @(negedge clk);
        check("hold restart busy", busy, 1);
        check("hold restart data", out_data, 8'hA5);
        start = 1'b0;
        collect("hold2", 0, 0, -1);
        check_frame("hold2");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hold2 quiet %0d", k), busy, 0);
        end

        // Reset while in LO of register 7
        for (int i = 0; i < 16; i++) regs[i] = 16'hA000 + 16'(i);
        start_frame("abort");
        collect("abort", 0, 0, 16);
        check("abort reached", aborted, 1);
        check("abort addr r7", rd_addr, 4'h7);
        check("abort lo data", out_data, 8'h07);
        #1 reset = 1'b1;
        #1;
        check("arst busy", busy, 0);
        check("arst done", done, 0);
        check("arst valid", out_valid, 0);
        check("arst data", out_data, 8'h00);
        check("arst addr", rd_addr, 4'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post rst idle", busy, 0);
        start_frame("post");
        collect("post", 0, 0, -1);
        check_frame("post");
        check("post r0 hi", got_q[1], 8'hA0);
        check("post r0 lo", got_q[2], 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
